pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_mc_cnt.sv | 48 ++++
 rtl/pipe_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
//   RegBus / ZeroWord : datapath width and its zero constant
//   Stall*            : {wb,mem,ex,id,if,pc} hold-enable encodings
//   state_e           : controller FSM states
package pipe_ctrl_pkg;

  localparam int unsigned RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic [RegBus-1:0] StatMax = '1;

  localparam int unsigned McCntW = 6;

  // A stall at stage k also holds every earlier stage.
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMcBusy = 2'd1,
    StFlush  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_mc_cnt.sv
// Multi-cycle countdown for the EX stage.
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : force count to zero (highest priority)
//   load       : load load_val
//   hold       : keep current count
//   cnt        : current remaining cycles
//   last       : cnt == 1, final cycle of the operation
// With no control asserted the count decrements, stopping at zero.
module pipe_mc_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [McCntW-1:0] load_val,
  input  logic              hold,
  output logic [McCntW-1:0] cnt,
  output logic              last
);

  logic [McCntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == McCntW'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall / flush controller with EX multi-cycle sequencing.
//   clk, rst          : clock, asynchronous active-low reset
//   stallreq_from_id  : load-use hazard stall request
//   ex_mc_start       : EX begins a multi-cycle op needing ex_mc_cycles extra cycles
//   ex_mc_cancel      : abort the in-flight multi-cycle op
//   stallreq_from_mem : MEM-stage stall request
//   excp_req          : exception, flush pipeline and redirect to excp_vector
//   stall             : {wb,mem,ex,id,if,pc} hold enables
//   flush / new_pc    : one-cycle flush with handler PC
//   ex_mc_busy        : multi-cycle op in progress
//   ex_mc_done        : one-cycle pulse, EX result valid
//   stall_cycles      : count of stalled cycles when PIPE_CTRL_STAT_EN is defined, else zero
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_from_id,
  input  logic              ex_mc_start,
  input  logic [5:0]        ex_mc_cycles,
  input  logic              ex_mc_cancel,
  input  logic              stallreq_from_mem,
  input  logic              excp_req,
  input  logic [RegBus-1:0] excp_vector,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [RegBus-1:0] new_pc,
  output logic              ex_mc_busy,
  output logic              ex_mc_done,
  output logic [RegBus-1:0] stall_cycles
);

  state_e state_q, state_d;
  logic [RegBus-1:0] vec_q;

  logic              cnt_clear, cnt_load, cnt_hold, cnt_last;
  logic [McCntW-1:0] cnt;

  logic mc_start_ok;
  logic ex_stall;

  // A zero-length op needs no extra cycles, so it never leaves IDLE.
  assign mc_start_ok = ex_mc_start && (ex_mc_cycles != '0);

  pipe_mc_cnt u_mc_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (ex_mc_cycles),
    .hold     (cnt_hold),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  // State register plus the captured handler PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      vec_q   <= ZeroWord;
    end else begin
      state_q <= state_d;
      if (excp_req) begin
        vec_q <= excp_vector;
      end
    end
  end

  // Next state and countdown control.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_hold  = 1'b0;
    if (excp_req) begin
      state_d   = StFlush;
      cnt_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mc_start_ok) begin
            state_d  = StMcBusy;
            cnt_load = 1'b1;
          end
        end
        StMcBusy: begin
          if (ex_mc_cancel) begin
            state_d   = StIdle;
            cnt_clear = 1'b1;
          end else if (stallreq_from_mem) begin
            cnt_hold = 1'b1;
          end else if (cnt_last) begin
            state_d   = StIdle;
            cnt_clear = 1'b1;
          end
        end
        StFlush: begin
          state_d = StIdle;
        end
        default: begin
          state_d   = StIdle;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  // EX holds the front of the pipe on the start cycle and every busy cycle but the last.
  assign ex_stall = ((state_q == StIdle) && mc_start_ok) ||
                    ((state_q == StMcBusy) && !ex_mc_cancel && !cnt_last);

  // Outputs. Gating with rst keeps stall quiet while reset is asserted.
  always_comb begin
    stall      = StallNone;
    flush      = 1'b0;
    new_pc     = ZeroWord;
    ex_mc_busy = 1'b0;
    ex_mc_done = 1'b0;
    if (rst) begin
      if ((state_q == StFlush) || excp_req) begin
        stall = StallNone;
      end else if (stallreq_from_mem) begin
        stall = StallMem;
      end else if (ex_stall) begin
        stall = StallEx;
      end else if (stallreq_from_id) begin
        stall = StallId;
      end

      if (state_q == StFlush) begin
        flush  = 1'b1;
        new_pc = vec_q;
      end

      ex_mc_busy = (state_q == StMcBusy);
      ex_mc_done = (state_q == StMcBusy) && cnt_last && !stallreq_from_mem &&
                   !ex_mc_cancel && !excp_req;
    end
  end

`ifdef PIPE_CTRL_STAT_EN
  logic [RegBus-1:0] stat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_q <= ZeroWord;
    end else if ((stall != StallNone) && (stat_q != StatMax)) begin
      stat_q <= stat_q + 1'b1;
    end
  end

  assign stall_cycles = stat_q;
`else
  assign stall_cycles = ZeroWord;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              stallreq_from_id, ex_mc_start, ex_mc_cancel, stallreq_from_mem, excp_req;
  logic [5:0]        ex_mc_cycles;
  logic [RegBus-1:0] excp_vector;
  logic [5:0]        stall;
  logic              flush, ex_mc_busy, ex_mc_done;
  logic [RegBus-1:0] new_pc, stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (stallreq_from_id),
    .ex_mc_start       (ex_mc_start),
    .ex_mc_cycles      (ex_mc_cycles),
    .ex_mc_cancel      (ex_mc_cancel),
    .stallreq_from_mem (stallreq_from_mem),
    .excp_req          (excp_req),
    .excp_vector       (excp_vector),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .ex_mc_busy        (ex_mc_busy),
    .ex_mc_done        (ex_mc_done),
    .stall_cycles      (stall_cycles)
  );

  typedef struct {
    logic        rst, id, start;
    logic [5:0]  n;
    logic        cancel, mem, excp;
    logic [31:0] vec;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy, e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic id, logic st, logic [5:0] n, logic cn, logic mm,
                              logic ex, logic [31:0] vc, logic [5:0] s, logic fl,
                              logic [31:0] pc, logic bz, logic dn);
    vec_t v;
    v.rst = r; v.id = id; v.start = st; v.n = n; v.cancel = cn; v.mem = mm; v.excp = ex;
    v.vec = vc; v.e_stall = s; v.e_flush = fl; v.e_pc = pc; v.e_busy = bz; v.e_done = dn;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stallreq_from_id = v.id; ex_mc_start = v.start; ex_mc_cycles = v.n;
    ex_mc_cancel = v.cancel; stallreq_from_mem = v.mem; excp_req = v.excp;
    excp_vector = v.vec;
  endtask

  vec_t idle_v;
  logic [31:0] exp_stat;

  initial begin
    idle_v = mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));

    //              rst id st  n cn mm ex vec            stall     fl pc             bz dn
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0,            6'b000000, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,            6'b000111, 0, 0,            0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0,            6'b011111, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            0, 0));
    // N=3 plain
    tbl.push_back(mk(1, 0, 1, 3, 0, 0, 0, 0,            6'b001111, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b001111, 0, 0,            1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b001111, 0, 0,            1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            0, 0));
    // N=3 with two MEM stall cycles at cnt=2
    tbl.push_back(mk(1, 0, 1, 3, 0, 0, 0, 0,            6'b001111, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b001111, 0, 0,            1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,            6'b011111, 0, 0,            1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,            6'b011111, 0, 0,            1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b001111, 0, 0,            1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            0, 0));
    // start while busy is ignored; ID stall shows once EX releases
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 0, 0,            6'b001111, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 1, 5, 0, 0, 0, 0,            6'b001111, 0, 0,            1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,            6'b000111, 0, 0,            1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            0, 0));
    // exception at cnt=5
    tbl.push_back(mk(1, 0, 1, 6, 0, 0, 0, 0,            6'b001111, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b001111, 0, 0,            1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h180,      6'b000000, 0, 0,            1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 1, 32'h180,      0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            0, 0));
    // cancel
    tbl.push_back(mk(1, 0, 1, 4, 0, 0, 0, 0,            6'b001111, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0,            6'b000000, 0, 0,            1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            0, 0));
    // back-to-back exceptions
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h200,      6'b000000, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h300,      6'b000000, 1, 32'h200,      0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 1, 32'h300,      0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            0, 0));
    // N=1
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0,            6'b001111, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            0, 0));
    // N=1 with MEM stall on the last cycle
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0,            6'b001111, 0, 0,            0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,            6'b011111, 0, 0,            1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            6'b000000, 0, 0,            0, 0));

    exp_stat = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check("stall", i, 32'(stall), 32'(tbl[i].e_stall));
      check("flush", i, 32'(flush), 32'(tbl[i].e_flush));
      check("new_pc", i, new_pc, tbl[i].e_pc);
      check("busy", i, 32'(ex_mc_busy), 32'(tbl[i].e_busy));
      check("done", i, 32'(ex_mc_done), 32'(tbl[i].e_done));
      if (!tbl[i].rst) begin
        check("stat_rst", i, stall_cycles, 32'h0);
        exp_stat = 0;
      end else if (tbl[i].e_stall != 6'b000000) begin
        exp_stat++;
      end
      @(posedge clk);
      #1;
    end
    drive(idle_v);
    @(negedge clk);
`ifdef PIPE_CTRL_STAT_EN
    check("stat_table", 0, stall_cycles, exp_stat);
`else
    check("stat_table", 0, stall_cycles, 32'h0);
`endif

    // Asynchronous reset in the middle of a multi-cycle op.
    @(posedge clk); #1;
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd5;
    @(posedge clk); #1;
    ex_mc_start = 1'b0; ex_mc_cycles = 6'd0;
    @(posedge clk); #1;
    check("busy_pre_rst", 0, 32'(ex_mc_busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("busy_async_rst", 0, 32'(ex_mc_busy), 32'h0);
    check("stall_async_rst", 0, 32'(stall), 32'h0);
    check("stat_async_rst", 0, stall_cycles, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_done_after_rst", k, 32'(ex_mc_done), 32'h0);
      check("idle_after_rst", k, 32'(ex_mc_busy), 32'h0);
    end

    // Seven ID-stall cycles for the statistics counter.
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      stallreq_from_id = 1'b1;
    end
    @(posedge clk); #1;
    stallreq_from_id = 1'b0;
    @(negedge clk);
`ifdef PIPE_CTRL_STAT_EN
    check("stat_seven", 0, stall_cycles, 32'd7);
`else
    check("stat_seven", 0, stall_cycles, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
